ber_checker_sync: RTL
=====================

Name: ber_checker_sync

Overview:
- Receive-side bit-error-rate checker after the slicer.
- Recovers I and Q hard bits from the slicer symbols and compares them against the transmitter PRBS reference bits.
- Searches automatically for the reference-to-receiver delay, locks, and accumulates per-lane symbol and error counts.
- Replaces the offline file-based BER post-processing with a parametrised, in-fabric checker that supports configurable depth, window and thresholds, loss-of-lock detection and counter saturation.

Parameters:
- NBT_SYM, 12, total bits of slicer symbols.
- SIGN_IS_ONE, 1, 1: recovered bit = symbol MSB; 0: recovered bit = ~MSB.
- MAX_DELAY, 64, depth of the reference delay line; delay candidates are 0..MAX_DELAY-1.
- NB_DELAY, 6, width of the delay index (clog2 of MAX_DELAY).
- WINDOW, 1024, strobes per evaluation window.
- NB_WIN, 11, window counter width (holds WINDOW).
- LOCK_THR, 10, max combined I+Q errors per window to declare lock.
- UNLOCK_THR, 100, combined I+Q errors per window above which lock is dropped.
- NB_CNT, 48, width of the accumulated symbol and error counters.

Ports:
- clk  in  1  system clock.
- i_reset  in  1  asynchronous active-low reset.
- i_enable  in  1  checker enable.
- i_sym_valid  in  1  one-cycle symbol strobe; all sym/ref inputs are sampled on it.
- i_sym_I  in  NBT_SYM  signed slicer output, I lane.
- i_sym_Q  in  NBT_SYM  signed slicer output, Q lane.
- i_ref_bit_I  in  1  transmitter PRBS bit, I lane.
- i_ref_bit_Q  in  1  transmitter PRBS bit, Q lane.
- i_clear_cnt  in  1  synchronous clear of the accumulated counters.
- o_locked  out  1  high in LOCKED state.
- o_delay  out  NB_DELAY  current candidate or locked delay.
- o_sym_cnt  out  NB_CNT  symbols compared while locked (per lane).
- o_err_cnt_I  out  NB_CNT  I errors accumulated while locked.
- o_err_cnt_Q  out  NB_CNT  Q errors accumulated while locked.
- o_wrap_cnt  out  16  number of full delay sweeps without lock.

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0, state IDLE, delay lines 0, window counter 0, window error sum 0.
- Delay line:
  - One MAX_DELAY-bit shift register per lane; shifts in the ref bit on every i_sym_valid, in every state.
  - Tap d is the ref bit sampled d strobes earlier; tap 0 is the current strobe's ref bit.
- Compare: on each strobe, err_X = recovered bit XOR tap[o_delay] of lane X. Only strobes change state or counters; cycles without i_sym_valid hold everything.
- States:
  - IDLE: entered when i_enable=0 (from any state, next cycle). o_delay=0, window cleared, accumulated counters held. i_enable=1 -> SEARCH.
  - SEARCH:
    - Counts WINDOW strobes and sums err_I+err_Q; the WINDOW-th strobe is included in the sum.
    - At window end, if sum<=LOCK_THR -> LOCKED, delay kept.
    - Otherwise delay+1. At MAX_DELAY-1 the delay wraps to 0 and o_wrap_cnt increments, saturating at 16'hFFFF.
    - The window counter and sum restart either way.
  - LOCKED:
    - Each strobe: o_sym_cnt+=1; o_err_cnt_I+=err_I; o_err_cnt_Q+=err_Q.
    - The window monitor keeps running. At window end, if sum>UNLOCK_THR -> SEARCH with delay+1 (same wrap rule); accumulated counters are held, not cleared.
    - sum<=UNLOCK_THR stays locked; LOCK_THR<sum<=UNLOCK_THR also stays locked (hysteresis).
- Latency: o_locked and o_delay update on the clock edge that samples the window-ending strobe; they are visible in the next cycle. Counter outputs are registered and reflect a strobe one cycle after it.
- Saturation: o_sym_cnt, o_err_cnt_I and o_err_cnt_Q stop at 2^NB_CNT-1 and never wrap. The window sum saturates at its width (clog2(2*WINDOW+1) bits).
- i_clear_cnt: zeroes o_sym_cnt, o_err_cnt_I, o_err_cnt_Q and o_wrap_cnt. It has priority over a same-cycle increment (result 0). It does not affect state, delay or the window.
- i_enable falling mid-window: window discarded; re-enable restarts the search at delay 0.

Test Plan:
- Lock at delay 17:
  - Stimulus: PRBS9 ref; symbols = ±256 mapped from ref delayed 17 strobes; no errors.
  - Response: SEARCH fails at delays 0..16 (≈50% errors); o_locked rises the cycle after strobe 18*1024; o_delay=17; error counters 0.
- Tolerated errors:
  - Stimulus: locked; flip 5 I bits and 3 Q bits within one window.
  - Response: o_err_cnt_I=5, o_err_cnt_Q=3; o_locked stays 1; o_sym_cnt equals the number of locked strobes.
- Loss of lock:
  - Stimulus: locked at 17; inject 150 errors in one window.
  - Response: o_locked falls after that window; o_delay=18; counters held; search continues and relocks at 17 after wrap; o_wrap_cnt=1.
- No correlation:
  - Stimulus: random symbols.
  - Response: never locks; o_wrap_cnt increments every 64 windows; o_sym_cnt stays 0.
- Priority and reset:
  - Stimulus: i_clear_cnt on the same cycle as an erroring strobe.
  - Response: all counters 0.
  - Stimulus: async i_reset low mid-window, between clock edges.
  - Response: outputs 0 immediately.
- Saturation:
  - Stimulus: NB_CNT=4; locked with all-error input and UNLOCK_THR=2*WINDOW.
  - Response: o_err_cnt_I holds at 15 and o_sym_cnt holds at 15; neither wraps.

Source files
------------

// File: rtl/ber_checker_sync.sv
// ber_checker_sync: receive-side BER checker placed after the slicer.
// The checker recovers the I and Q hard bits from the slicer symbols. It
// compares them against delayed copies of the transmitter PRBS reference.
// It sweeps the reference delay one evaluation window at a time until the
// error sum is low enough to lock. While locked it accumulates saturating
// per-lane symbol and error counts. It drops lock when a window exceeds the
// unlock threshold.
//
// Ports:
//   clk          system clock
//   i_reset      asynchronous active-low reset
//   i_enable     checker enable (low forces IDLE)
//   i_sym_valid  one-cycle symbol strobe; sym/ref inputs sampled on it
//   i_sym_I/Q    signed slicer symbols
//   i_ref_bit_I/Q transmitter PRBS reference bits
//   i_clear_cnt  synchronous clear of accumulated counters
//   o_locked     high in LOCKED
//   o_delay      current candidate / locked delay
//   o_sym_cnt    symbols compared while locked
//   o_err_cnt_I/Q errors accumulated while locked
//   o_wrap_cnt   full delay sweeps without lock
//
// state  | meaning
// IDLE   | disabled; delay 0, window cleared, counters held
// SEARCH | evaluating one delay candidate per window
// LOCKED | accumulating counters, window monitor watching for loss of lock
module ber_checker_sync #(
  parameter int NBT_SYM     = 12,
  parameter int SIGN_IS_ONE = 1,
  parameter int MAX_DELAY   = 64,
  parameter int NB_DELAY    = 6,
  parameter int WINDOW      = 1024,
  parameter int NB_WIN      = 11,
  parameter int LOCK_THR    = 10,
  parameter int UNLOCK_THR  = 100,
  parameter int NB_CNT      = 48
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sym_valid,
  input  logic [NBT_SYM-1:0]  i_sym_I,
  input  logic [NBT_SYM-1:0]  i_sym_Q,
  input  logic                i_ref_bit_I,
  input  logic                i_ref_bit_Q,
  input  logic                i_clear_cnt,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_CNT-1:0]   o_sym_cnt,
  output logic [NB_CNT-1:0]   o_err_cnt_I,
  output logic [NB_CNT-1:0]   o_err_cnt_Q,
  output logic [15:0]         o_wrap_cnt
);

  localparam int NB_SUM  = $clog2(2*WINDOW+1);
  localparam int NB_SUMW = NB_SUM + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [NB_DELAY-1:0] delay_q, delay_d;
  logic [NB_WIN-1:0]   win_q, win_d;
  logic [NB_SUM-1:0]   sum_q, sum_d;
  logic [15:0]         wrap_q, wrap_d;
  logic [NB_CNT-1:0]   sym_cnt_q, sym_cnt_d;
  logic [NB_CNT-1:0]   err_cnt_i_q, err_cnt_i_d;
  logic [NB_CNT-1:0]   err_cnt_q_q, err_cnt_q_d;
  // Tap 0 is the live ref bit, so only MAX_DELAY-1 past strobes need storing.
  logic [MAX_DELAY-2:0] dl_i_q, dl_i_d;
  logic [MAX_DELAY-2:0] dl_q_q, dl_q_d;

  logic [MAX_DELAY-1:0] taps_i, taps_q;
  logic                 rx_bit_i, rx_bit_q;
  logic                 err_i, err_q;
  logic [NB_SUMW-1:0]   sum_wide;
  logic [NB_SUM-1:0]    sum_new;
  logic                 win_end;
  logic                 delay_last;
  logic [NB_DELAY-1:0]  delay_next;
  logic [15:0]          wrap_next;
  logic                 unused_sym;

  assign taps_i   = {dl_i_q, i_ref_bit_I};
  assign taps_q   = {dl_q_q, i_ref_bit_Q};
  assign rx_bit_i = (SIGN_IS_ONE != 0) ? i_sym_I[NBT_SYM-1] : ~i_sym_I[NBT_SYM-1];
  assign rx_bit_q = (SIGN_IS_ONE != 0) ? i_sym_Q[NBT_SYM-1] : ~i_sym_Q[NBT_SYM-1];
  assign err_i    = rx_bit_i ^ taps_i[delay_q];
  assign err_q    = rx_bit_q ^ taps_q[delay_q];
  // Only the sign of each symbol matters to a hard-bit checker.
  assign unused_sym = ^{i_sym_I[NBT_SYM-2:0], i_sym_Q[NBT_SYM-2:0]};

  // The sum includes the current strobe, so the window-ending strobe counts.
  assign sum_wide   = {1'b0, sum_q} + NB_SUMW'(err_i) + NB_SUMW'(err_q);
  assign sum_new    = sum_wide[NB_SUM] ? {NB_SUM{1'b1}} : sum_wide[NB_SUM-1:0];
  assign win_end    = (win_q == NB_WIN'(WINDOW-1));
  assign delay_last = (delay_q == NB_DELAY'(MAX_DELAY-1));
  assign delay_next = delay_last ? '0 : delay_q + NB_DELAY'(1);
  assign wrap_next  = (delay_last && (wrap_q != 16'hFFFF)) ? wrap_q + 16'd1 : wrap_q;

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    win_d       = win_q;
    sum_d       = sum_q;
    wrap_d      = wrap_q;
    sym_cnt_d   = sym_cnt_q;
    err_cnt_i_d = err_cnt_i_q;
    err_cnt_q_d = err_cnt_q_q;
    dl_i_d      = dl_i_q;
    dl_q_d      = dl_q_q;

    if (i_sym_valid) begin
      dl_i_d = taps_i[MAX_DELAY-2:0];
      dl_q_d = taps_q[MAX_DELAY-2:0];
    end

    if (!i_enable) begin
      state_d = IDLE;
      delay_d = '0;
      win_d   = '0;
      sum_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEARCH;
        SEARCH, LOCKED: begin
          if (i_sym_valid) begin
            if (win_end) begin
              win_d = '0;
              sum_d = '0;
              if (state_q == SEARCH) begin
                if (sum_new <= NB_SUM'(LOCK_THR)) begin
                  state_d = LOCKED;
                end else begin
                  delay_d = delay_next;
                  wrap_d  = wrap_next;
                end
              end else if (sum_new > NB_SUM'(UNLOCK_THR)) begin
                state_d = SEARCH;
                delay_d = delay_next;
                wrap_d  = wrap_next;
              end
            end else begin
              win_d = win_q + NB_WIN'(1);
              sum_d = sum_new;
            end

            if (state_q == LOCKED) begin
              if (!(&sym_cnt_q))            sym_cnt_d   = sym_cnt_q + NB_CNT'(1);
              if (err_i && !(&err_cnt_i_q)) err_cnt_i_d = err_cnt_i_q + NB_CNT'(1);
              if (err_q && !(&err_cnt_q_q)) err_cnt_q_d = err_cnt_q_q + NB_CNT'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear wins over any same-cycle increment.
    if (i_clear_cnt) begin
      sym_cnt_d   = '0;
      err_cnt_i_d = '0;
      err_cnt_q_d = '0;
      wrap_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      delay_q     <= '0;
      win_q       <= '0;
      sum_q       <= '0;
      wrap_q      <= '0;
      sym_cnt_q   <= '0;
      err_cnt_i_q <= '0;
      err_cnt_q_q <= '0;
      dl_i_q      <= '0;
      dl_q_q      <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      win_q       <= win_d;
      sum_q       <= sum_d;
      wrap_q      <= wrap_d;
      sym_cnt_q   <= sym_cnt_d;
      err_cnt_i_q <= err_cnt_i_d;
      err_cnt_q_q <= err_cnt_q_d;
      dl_i_q      <= dl_i_d;
      dl_q_q      <= dl_q_d;
    end
  end

  assign o_locked    = (state_q == LOCKED);
  assign o_delay     = delay_q;
  assign o_sym_cnt   = sym_cnt_q;
  assign o_err_cnt_I = err_cnt_i_q;
  assign o_err_cnt_Q = err_cnt_q_q;
  assign o_wrap_cnt  = wrap_q;

endmodule
